// File: rtl/frequency_meter.sv
// rtl/frequency_meter.sv - counts meas_clk rising edges per clk gate window via a Gray-coded crossing
// Optional FREQ_METER_AVG_EN: report the mean of the last four windows.
`timescale 1ns/1ps
module frequency_meter #(
  parameter int GATE_CYCLES = 27_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_clk,
  input  logic             enable,
  output logic [CNT_W-1:0] measured_freq,
  output logic             new_data_valid,
  output logic             meas_clk_dead
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(SYNC_STAGES + 1);

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Only differences of the count are used, so reset release needs no synchroniser here.
  logic [CNT_W-1:0] mcnt;
  logic [CNT_W-1:0] mgray;

  always_ff @(posedge meas_clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt  <= '0;
      mgray <= '0;
    end else begin
      mcnt  <= mcnt + CNT_W'(1);
      mgray <= mcnt ^ (mcnt >> 1);
    end
  end

  logic [CNT_W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= mgray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [CNT_W-1:0] sample;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] delta;

  assign sample = gray2bin(sync_q[SYNC_STAGES-1]);
  assign delta  = sample - base;

`ifdef FREQ_METER_AVG_EN
  // The newest of the four entries is delta itself, so only the previous three are stored.
  logic [CNT_W-1:0] hist [3];
  logic [1:0]       wins;
  logic [CNT_W+1:0] sum;

  assign sum = {2'b00, delta} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
`endif

  typedef enum logic [1:0] {IDLE, PRIME, GATE} state_t;
  state_t        state;
  logic [PW-1:0] pcnt;
  logic [GW-1:0] gcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pcnt           <= '0;
      gcnt           <= '0;
      base           <= '0;
      measured_freq  <= '0;
      new_data_valid <= 1'b0;
      meas_clk_dead  <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      for (int i = 0; i < 3; i++) hist[i] <= '0;
      wins <= '0;
`endif
    end else begin
      new_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= PRIME;
            pcnt  <= '0;
`ifdef FREQ_METER_AVG_EN
            for (int i = 0; i < 3; i++) hist[i] <= '0;
            wins <= '0;
`endif
          end
        end
        PRIME: begin
          if (!enable) begin
            state <= IDLE;
          end else if (pcnt == P_LAST) begin
            base  <= sample;
            gcnt  <= '0;
            state <= GATE;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        GATE: begin
          // Disable wins even on the terminal-count cycle: the partial window is dropped.
          if (!enable) begin
            state <= IDLE;
          end else if (gcnt == G_LAST) begin
            base <= sample;
            gcnt <= '0;
`ifdef FREQ_METER_AVG_EN
            hist[0] <= delta;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            if (wins == 2'd3) begin
              measured_freq  <= CNT_W'(sum >> 2);
              new_data_valid <= 1'b1;
              meas_clk_dead  <= (delta == '0);
            end else begin
              wins <= wins + 2'd1;
            end
`else
            measured_freq  <= delta;
            new_data_valid <= 1'b1;
            meas_clk_dead  <= (delta == '0);
`endif
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// tb/tb_frequency_meter.sv - self-checking bench for frequency_meter
`timescale 1ns/1ps
module tb_frequency_meter;

  localparam int  G      = 400;
  localparam int  CW     = 12;
  localparam int  SS     = 2;
  localparam real CLK_NS = 10.0;
`ifdef FREQ_METER_AVG_EN
  localparam int AVG_WIN = 4;
`else
  localparam int AVG_WIN = 1;
`endif
  // Edges waited from the enable-sampling edge (inclusive) to the first visible pulse.
  localparam int FIRST_WAIT = SS + 2 + G * AVG_WIN + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          meas_clk = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] measured_freq;
  logic          new_data_valid;
  logic          meas_clk_dead;

  real meas_h   = 2.5;
  bit  meas_run = 1'b1;
  int  tests    = 0;
  int  fails    = 0;

  typedef struct {
    real half_ns;
    real freq;
  } vec_t;
  vec_t vecs[7];

  frequency_meter #(
    .GATE_CYCLES(G),
    .CNT_W(CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .meas_clk(meas_clk),
    .enable(enable),
    .measured_freq(measured_freq),
    .new_data_valid(new_data_valid),
    .meas_clk_dead(meas_clk_dead)
  );

  always #5 clk = ~clk;

  always begin
    if (!meas_run) begin
      meas_clk = 1'b0;
      wait (meas_run);
    end else begin
      #(meas_h) meas_clk = ~meas_clk;
    end
  end

  // Edges per gate window for a meas_clk with the given half period.
  function automatic real ref_freq(input real half_ns);
    return real'(G) * CLK_NS / (2.0 * half_ns);
  endfunction

  task automatic check_eq(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input longint act, input real exp);
    real d;
    tests++;
    d = real'(act) - exp;
    if (d < 0.0) d = -d;
    if (d > 1.0) begin
      fails++;
      $display("FAIL %s: got %0d expected %0f +/-1", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int limit, output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      tick();
      n++;
      got = new_data_valid;
    end
  endtask

  task automatic skip_report(input string name);
    int n;
    bit got;
    wait_pulse(FIRST_WAIT + G, n, got);
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s: no pulse within %0d cycles", name, FIRST_WAIT + G);
    end
  endtask

  // Entered just after a pulse; drops windows polluted by the change, then checks a clean one.
  task automatic measure(input string name, input bit run, input real h, input real exp);
    int n;
    bit got;
    meas_h   = h;
    meas_run = run;
    for (int i = 0; i < AVG_WIN; i++) skip_report(name);
    wait_pulse(G + 2, n, got);
    check_eq({name, " spacing"}, got ? n : -1, G);
    check_near({name, " freq"}, measured_freq, exp);
    check_eq({name, " dead"}, meas_clk_dead, (exp == 0.0) ? 1 : 0);
  endtask

  task automatic first_pulse(input string name, input real exp);
    int n;
    bit got;
    wait_pulse(FIRST_WAIT + 10, n, got);
    check_eq({name, " latency"}, got ? n : -1, FIRST_WAIT);
    check_near({name, " freq"}, measured_freq, exp);
  endtask

  initial begin
    int          n;
    bit          got;
    logic [CW-1:0] hold_f;
    logic          hold_d;
    real           h;

    // With a 12-bit counter, windows near 2000 edges make mcnt wrap within a window.
    vecs[0] = '{2.5, 800.0};
    vecs[1] = '{1.0, 2000.0};
    vecs[2] = '{2.0, 1000.0};
    vecs[3] = '{5.0, 400.0};
    vecs[4] = '{4.0, 500.0};
    vecs[5] = '{3.0, 666.667};
    vecs[6] = '{10.0, 200.0};

    repeat (3) tick();
    check_eq("reset measured_freq", measured_freq, 0);
    check_eq("reset new_data_valid", new_data_valid, 0);
    check_eq("reset meas_clk_dead", meas_clk_dead, 0);
    rst_n = 1'b1;
    tick();

    enable = 1'b1;
    first_pulse("nominal", 800.0);
    tick();
    check_eq("pulse width", new_data_valid, 0);
    wait_pulse(G + 2, n, got);
    check_eq("steady spacing", got ? n : -1, G - 1);

    for (int i = 0; i < 7; i++) begin
      measure($sformatf("vec%0d", i), 1'b1, vecs[i].half_ns, vecs[i].freq);
    end

    for (int i = 0; i < 5; i++) begin
      h = real'($urandom_range(10, 60)) / 10.0;
      measure($sformatf("rand%0d", i), 1'b1, h, ref_freq(h));
    end

    measure("dead clock", 1'b0, 1.0, 0.0);
    measure("restart", 1'b1, 5.0, 400.0);

    repeat (100) tick();
    enable = 1'b0;
    hold_f = measured_freq;
    hold_d = meas_clk_dead;
    wait_pulse(2 * G, n, got);
    check_eq("disabled no pulse", got, 0);
    check_eq("disabled hold freq", measured_freq, hold_f);
    check_eq("disabled hold dead", meas_clk_dead, hold_d);
    enable = 1'b1;
    first_pulse("re-enable", 400.0);

    repeat (G - 1) tick();
    enable = 1'b0;
    wait_pulse(20, n, got);
    check_eq("disable at terminal count", got, 0);
    enable = 1'b1;
    first_pulse("after tc disable", 400.0);

    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async reset freq", measured_freq, 0);
    check_eq("async reset valid", new_data_valid, 0);
    check_eq("async reset dead", meas_clk_dead, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    first_pulse("after reset", 400.0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
